// File: rtl/mru_frame_streamer.sv
// Streams snapshots of a 4-entry move-to-front tracker over valid/ready, index 0 first.
// List changes seen while a frame is in flight are coalesced into one follow-up frame.
module mru_frame_streamer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  input  logic              in_valid_0,
  input  logic              in_valid_1,
  input  logic              in_valid_2,
  input  logic              in_valid_3,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_index,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [3:0][DATA_W-1:0]  shadow_data_q, shadow_data_d;
  logic [3:0]              shadow_vld_q, shadow_vld_d;
  logic [3:0][DATA_W-1:0]  frame_data_q, frame_data_d;
  logic [3:0]              frame_vld_q, frame_vld_d;
  logic [3:0][DATA_W-1:0]  prev_data_q, prev_data_d;
  logic [3:0]              prev_vld_q, prev_vld_d;
  logic [1:0]              idx_q, idx_d;
  logic                    pending_q, pending_d;
  logic [CNT_W-1:0]        drop_cnt_q, drop_cnt_d;

  logic [3:0][DATA_W-1:0]  in_data;
  logic [3:0]              in_vld;
  logic [3:0]              shadow_match;
  logic [3:0]              prev_match;
  logic                    in_eq_shadow;
  logic                    in_eq_prev;
  logic                    in_any_vld;
  logic                    frame_last;
  logic [CNT_W-1:0]        drop_inc;

  assign in_data = {in_3, in_2, in_1, in_0};
  assign in_vld  = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};

  // Data in invalid positions never participates in snapshot equality.
  for (genvar gi = 0; gi < 4; gi++) begin : g_match
    assign shadow_match[gi] = !in_vld[gi] || (in_data[gi] == shadow_data_q[gi]);
    assign prev_match[gi]   = !in_vld[gi] || (in_data[gi] == prev_data_q[gi]);
  end

  assign in_eq_shadow = (in_vld == shadow_vld_q) && (&shadow_match);
  assign in_eq_prev   = (in_vld == prev_vld_q) && (&prev_match);
  assign in_any_vld   = |in_vld;
  assign frame_last   = ~|(frame_vld_q & (4'b1110 << idx_q));
  assign drop_inc     = (drop_cnt_q == '1) ? drop_cnt_q : drop_cnt_q + CNT_W'(1);

  function automatic logic [1:0] lowest_valid(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic logic [1:0] next_valid(input logic [3:0] v, input logic [1:0] cur);
    logic [1:0] r;
    r = cur;
    for (int i = 3; i >= 0; i--) begin
      if (v[i] && (i > int'(cur))) r = 2'(i);
    end
    return r;
  endfunction

  always_comb begin
    state_d       = state_q;
    shadow_data_d = shadow_data_q;
    shadow_vld_d  = shadow_vld_q;
    frame_data_d  = frame_data_q;
    frame_vld_d   = frame_vld_q;
    prev_data_d   = in_data;
    prev_vld_d    = in_vld;
    idx_d         = idx_q;
    pending_d     = pending_q;
    drop_cnt_d    = drop_cnt_q;

    case (state_q)
      IDLE: begin
        if (!in_eq_shadow) begin
          shadow_data_d = in_data;
          shadow_vld_d  = in_vld;
          if (in_any_vld) begin
            frame_data_d = in_data;
            frame_vld_d  = in_vld;
            idx_d        = lowest_valid(in_vld);
            state_d      = SEND;
          end
        end
      end

      SEND: begin
        if (out_ready && frame_last) begin
          pending_d = 1'b0;
          if (!in_eq_shadow && in_any_vld) begin
            shadow_data_d = in_data;
            shadow_vld_d  = in_vld;
            frame_data_d  = in_data;
            frame_vld_d   = in_vld;
            idx_d         = lowest_valid(in_vld);
          end else begin
            state_d = IDLE;
            if (!in_any_vld) begin
              shadow_data_d = in_data;
              shadow_vld_d  = in_vld;
            end
            // The list moved and came back: the intermediate change was lost.
            if (pending_q && in_eq_shadow) drop_cnt_d = drop_inc;
          end
        end else begin
          if (out_ready) idx_d = next_valid(frame_vld_q, idx_q);
          if (!in_eq_prev) begin
            if (!pending_q) pending_d = 1'b1;
            else            drop_cnt_d = drop_inc;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q       <= IDLE;
      shadow_data_q <= '0;
      shadow_vld_q  <= '0;
      frame_data_q  <= '0;
      frame_vld_q   <= '0;
      prev_data_q   <= '0;
      prev_vld_q    <= '0;
      idx_q         <= 2'd0;
      pending_q     <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      shadow_data_q <= shadow_data_d;
      shadow_vld_q  <= shadow_vld_d;
      frame_data_q  <= frame_data_d;
      frame_vld_q   <= frame_vld_d;
      prev_data_q   <= prev_data_d;
      prev_vld_q    <= prev_vld_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_data  = out_valid ? frame_data_q[idx_q] : '0;
  assign out_index = out_valid ? idx_q : 2'd0;
  assign out_last  = out_valid && frame_last;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_mru_frame_streamer.sv
// Directed bench for mru_frame_streamer: a table of per-cycle vectors plus
// hand-written reset-mid-frame and counter-saturation sequences.
module tb_mru_frame_streamer;

  logic       clk = 1'b0;
  logic       reset_in;
  logic [7:0] in_0, in_1, in_2, in_3;
  logic       in_valid_0, in_valid_1, in_valid_2, in_valid_3;
  logic [7:0] out_data;
  logic [1:0] out_index;
  logic       out_last, out_valid, out_ready, busy;
  logic [7:0] drop_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mru_frame_streamer #(.DATA_W(8), .CNT_W(8)) dut (
    .clk_in     (clk),
    .reset_in   (reset_in),
    .in_0       (in_0),
    .in_1       (in_1),
    .in_2       (in_2),
    .in_3       (in_3),
    .in_valid_0 (in_valid_0),
    .in_valid_1 (in_valid_1),
    .in_valid_2 (in_valid_2),
    .in_valid_3 (in_valid_3),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  // One record per clock cycle: inputs driven for that cycle and the outputs
  // expected just before its rising edge. d packs {in_3, in_2, in_1, in_0}.
  typedef struct {
    logic        rst;
    logic [31:0] d;
    logic [3:0]  v;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  ei;
    logic        el;
    logic        eb;
    logic [7:0]  edrop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [31:0] d, logic [3:0] v, logic rdy, logic ev,
                              logic [7:0] ed, logic [1:0] ei, logic el, logic eb, logic [7:0] edrop);
    vec_t t;
    t.rst = rst; t.d = d; t.v = v; t.rdy = rdy; t.ev = ev;
    t.ed = ed; t.ei = ei; t.el = el; t.eb = eb; t.edrop = edrop;
    return t;
  endfunction

  // Idle cycle: nothing on the output port.
  function automatic vec_t idl(logic [31:0] d, logic [3:0] v, logic [7:0] edrop);
    return mk(1'b0, d, v, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, edrop);
  endfunction

  // Beat cycle: a valid entry is on the output port.
  function automatic vec_t bt(logic [31:0] d, logic [3:0] v, logic rdy, logic [7:0] ed,
                              logic [1:0] ei, logic el, logic [7:0] edrop);
    return mk(1'b0, d, v, rdy, 1'b1, ed, ei, el, 1'b1, edrop);
  endfunction

  task automatic apply(input vec_t t, input string name);
    logic [20:0] act, exp;
    reset_in  = t.rst;
    {in_3, in_2, in_1, in_0} = t.d;
    {in_valid_3, in_valid_2, in_valid_1, in_valid_0} = t.v;
    out_ready = t.rdy;
    @(negedge clk);
    act = {out_valid, out_data, out_index, out_last, busy, drop_cnt};
    exp = {t.ev, t.ed, t.ei, t.el, t.eb, t.edrop};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got valid=%b data=%h idx=%0d last=%b busy=%b drop=%0d, want valid=%b data=%h idx=%0d last=%b busy=%b drop=%0d",
               name, out_valid, out_data, out_index, out_last, busy, drop_cnt,
               t.ev, t.ed, t.ei, t.el, t.eb, t.edrop);
    end else begin
      $display("[TB] %s: valid=%b data=%h idx=%0d last=%b busy=%b drop=%0d",
               name, out_valid, out_data, out_index, out_last, busy, drop_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    localparam logic [31:0] C  = 32'h01020304;  // entries 4,3,2,1
    localparam logic [31:0] F1 = 32'h281E140A;  // entries 10,20,30,40
    localparam logic [31:0] L1 = 32'h00000005;  // {5}
    localparam logic [31:0] L2 = 32'h00000506;  // {6,5}
    localparam logic [31:0] L3 = 32'h00050607;  // {7,6,5}
    localparam logic [31:0] F2 = 32'h00000C0B;  // {0B,0C}
    localparam logic [31:0] G  = 32'h0023AA21;  // valid at 0 and 2, junk at 1
    localparam logic [31:0] H  = 32'h44000000;  // valid only at 3
    int exp_drop;

    reset_in = 1'b1;
    out_ready = 1'b1;
    {in_3, in_2, in_1, in_0} = '0;
    {in_valid_3, in_valid_2, in_valid_1, in_valid_0} = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then all-invalid inputs for 5 cycles.
    tbl.push_back(mk(1'b1, 32'h0, 4'h0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'd0));
    for (int i = 0; i < 5; i++) tbl.push_back(idl(32'h0, 4'b0000, 8'd0));
    // Single-entry list.
    tbl.push_back(idl(32'h1, 4'b0001, 8'd0));
    tbl.push_back(bt(32'h1, 4'b0001, 1'b1, 8'h01, 2'd0, 1'b1, 8'd0));
    tbl.push_back(idl(32'h1, 4'b0001, 8'd0));
    tbl.push_back(idl(32'h1, 4'b0001, 8'd0));
    // Four entries with a 3-cycle stall on beat 2.
    tbl.push_back(idl(C, 4'b1111, 8'd0));
    tbl.push_back(bt(C, 4'b1111, 1'b1, 8'h04, 2'd0, 1'b0, 8'd0));
    for (int i = 0; i < 3; i++) tbl.push_back(bt(C, 4'b1111, 1'b0, 8'h03, 2'd1, 1'b0, 8'd0));
    tbl.push_back(bt(C, 4'b1111, 1'b1, 8'h03, 2'd1, 1'b0, 8'd0));
    tbl.push_back(bt(C, 4'b1111, 1'b1, 8'h02, 2'd2, 1'b0, 8'd0));
    tbl.push_back(bt(C, 4'b1111, 1'b1, 8'h01, 2'd3, 1'b1, 8'd0));
    tbl.push_back(idl(C, 4'b1111, 8'd0));
    // Three changes during a stalled frame, then a back-to-back frame.
    tbl.push_back(idl(F1, 4'b1111, 8'd0));
    tbl.push_back(bt(L1, 4'b0001, 1'b0, 8'h0A, 2'd0, 1'b0, 8'd0));
    tbl.push_back(bt(L2, 4'b0011, 1'b0, 8'h0A, 2'd0, 1'b0, 8'd0));
    tbl.push_back(bt(L3, 4'b0111, 1'b0, 8'h0A, 2'd0, 1'b0, 8'd1));
    tbl.push_back(bt(L3, 4'b0111, 1'b1, 8'h0A, 2'd0, 1'b0, 8'd2));
    tbl.push_back(bt(L3, 4'b0111, 1'b1, 8'h14, 2'd1, 1'b0, 8'd2));
    tbl.push_back(bt(L3, 4'b0111, 1'b1, 8'h1E, 2'd2, 1'b0, 8'd2));
    tbl.push_back(bt(L3, 4'b0111, 1'b1, 8'h28, 2'd3, 1'b1, 8'd2));
    tbl.push_back(bt(L3, 4'b0111, 1'b1, 8'h07, 2'd0, 1'b0, 8'd2));
    tbl.push_back(bt(L3, 4'b0111, 1'b1, 8'h06, 2'd1, 1'b0, 8'd2));
    tbl.push_back(bt(L3, 4'b0111, 1'b1, 8'h05, 2'd2, 1'b1, 8'd2));
    tbl.push_back(idl(L3, 4'b0111, 8'd2));
    // Change then revert on the final handshake: no second frame, one drop.
    tbl.push_back(idl(F2, 4'b0011, 8'd2));
    tbl.push_back(bt(32'h9, 4'b0001, 1'b0, 8'h0B, 2'd0, 1'b0, 8'd2));
    tbl.push_back(bt(32'h9, 4'b0001, 1'b1, 8'h0B, 2'd0, 1'b0, 8'd2));
    tbl.push_back(bt(F2, 4'b0011, 1'b1, 8'h0C, 2'd1, 1'b1, 8'd2));
    tbl.push_back(idl(F2, 4'b0011, 8'd3));
    tbl.push_back(idl(F2, 4'b0011, 8'd3));
    // Non-contiguous valids skip position 1; a lone valid at position 3.
    tbl.push_back(idl(G, 4'b0101, 8'd3));
    tbl.push_back(bt(G, 4'b0101, 1'b1, 8'h21, 2'd0, 1'b0, 8'd3));
    tbl.push_back(bt(G, 4'b0101, 1'b1, 8'h23, 2'd2, 1'b1, 8'd3));
    tbl.push_back(idl(G, 4'b0101, 8'd3));
    tbl.push_back(idl(H, 4'b1000, 8'd3));
    tbl.push_back(bt(H, 4'b1000, 1'b1, 8'h44, 2'd3, 1'b1, 8'd3));
    tbl.push_back(idl(H, 4'b1000, 8'd3));
    // Tracker reset goes silently into shadow, so the same list re-sends.
    tbl.push_back(idl(32'h0, 4'b0000, 8'd3));
    tbl.push_back(idl(32'h0, 4'b0000, 8'd3));
    tbl.push_back(idl(H, 4'b1000, 8'd3));
    tbl.push_back(bt(H, 4'b1000, 1'b1, 8'h44, 2'd3, 1'b1, 8'd3));
    tbl.push_back(idl(H, 4'b1000, 8'd3));
    // Junk in an invalid position is not a change.
    tbl.push_back(idl(32'h44000099, 4'b1000, 8'd3));
    tbl.push_back(idl(32'h44000099, 4'b1000, 8'd3));

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Reset after beat 1 of 4, then the same list is resent from index 0.
    apply(idl(C, 4'b1111, 8'd3), "rst_mid.capture");
    apply(bt(C, 4'b1111, 1'b1, 8'h04, 2'd0, 1'b0, 8'd3), "rst_mid.beat0");
    apply(mk(1'b1, C, 4'b1111, 1'b1, 1'b1, 8'h03, 2'd1, 1'b0, 1'b1, 8'd3), "rst_mid.assert");
    apply(idl(C, 4'b1111, 8'd0), "rst_mid.after");
    apply(bt(C, 4'b1111, 1'b1, 8'h04, 2'd0, 1'b0, 8'd0), "rst_mid.re0");
    apply(bt(C, 4'b1111, 1'b1, 8'h03, 2'd1, 1'b0, 8'd0), "rst_mid.re1");
    apply(bt(C, 4'b1111, 1'b1, 8'h02, 2'd2, 1'b0, 8'd0), "rst_mid.re2");
    apply(bt(C, 4'b1111, 1'b1, 8'h01, 2'd3, 1'b1, 8'd0), "rst_mid.re3");
    apply(idl(C, 4'b1111, 8'd0), "rst_mid.idle");

    // Stalled single-entry frame while the input toggles every cycle:
    // first change sets pending, every later one counts, saturating at 255.
    apply(mk(1'b0, 32'h1, 4'b0001, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'd0), "sat.capture");
    for (int k = 0; k < 300; k++) begin
      exp_drop = (k == 0) ? 0 : ((k - 1) > 255 ? 255 : (k - 1));
      apply(bt((k % 2) ? 32'h3 : 32'h2, 4'b0001, 1'b0, 8'h01, 2'd0, 1'b1, 8'(exp_drop)),
            $sformatf("sat[%0d]", k));
    end
    apply(bt(32'h3, 4'b0001, 1'b1, 8'h01, 2'd0, 1'b1, 8'd255), "sat.release");
    apply(bt(32'h3, 4'b0001, 1'b1, 8'h03, 2'd0, 1'b1, 8'd255), "sat.next");
    apply(idl(32'h3, 4'b0001, 8'd255), "sat.idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
